// File: rtl/sel_pkg.sv
// Shared types and helpers for the select decoder path.
package sel_pkg;

  localparam int unsigned SEL_W_DEF = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    GUARD  = 2'd2
  } state_e;

  // One-hot output width for a binary select of width sel_w.
  function automatic int unsigned out_w(input int unsigned sel_w);
    return 32'(1) << sel_w;
  endfunction

endpackage

// File: rtl/sel_onehot_dec.sv
// Combinational binary-to-one-hot decoder.
module sel_onehot_dec
  import sel_pkg::*;
#(
  parameter int unsigned SEL_W = SEL_W_DEF,
  localparam int unsigned OUT_W = out_w(SEL_W)
) (
  input  logic [SEL_W-1:0] i_sel,
  output logic [OUT_W-1:0] o_onehot
);

  // Exactly one bit set for every code.
  always_comb begin
    o_onehot        = '0;
    o_onehot[i_sel] = 1'b1;
  end

endmodule

// File: rtl/select_decoder_seq.sv
// Accepts a select code, holds its one-hot enable for a fixed window, then
// forces an all-zero guard gap before the next code (break-before-make).
module select_decoder_seq
  import sel_pkg::*;
#(
  parameter int unsigned SEL_W        = SEL_W_DEF,
  parameter int unsigned HOLD_CYCLES  = 4,
  parameter int unsigned GUARD_CYCLES = 1,
  parameter int unsigned CNT_W        = 4,
  localparam int unsigned OUT_W       = out_w(SEL_W)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [SEL_W-1:0] sel_i,
  input  logic             sel_valid_i,
  output logic             sel_ready_o,
  input  logic             flush_i,
  output logic [OUT_W-1:0] en_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GUARD_LOAD =
    (GUARD_CYCLES > 0) ? CNT_W'(GUARD_CYCLES - 1) : '0;

  state_e           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [OUT_W-1:0] r_en;
  logic             r_done;
  logic             r_busy;
  logic             r_ready;

  logic [OUT_W-1:0] w_dec;
  logic             w_accept;

  sel_onehot_dec #(
    .SEL_W (SEL_W)
  ) u_dec (
    .i_sel    (sel_i),
    .o_onehot (w_dec)
  );

  // A code is taken only when idle, offered, and not being flushed.
  assign w_accept = sel_valid_i && r_ready && !flush_i;

  // Sequencer: one shared down-counter times both the hold and guard windows.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_en    <= '0;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
      r_ready <= 1'b1;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_state <= ACTIVE;
            r_en    <= w_dec;
            r_cnt   <= HOLD_LOAD;
            r_busy  <= 1'b1;
            r_ready <= 1'b0;
          end
        end
        ACTIVE: begin
          if (r_cnt == '0 || flush_i) begin
            r_en   <= '0;
            r_done <= 1'b1;
            if (GUARD_CYCLES == 0) begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
              r_ready <= 1'b1;
            end else begin
              r_state <= GUARD;
              r_cnt   <= GUARD_LOAD;
            end
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        GUARD: begin
          if (r_cnt == '0) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_ready <= 1'b1;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        default: begin
          r_state <= IDLE;
          r_en    <= '0;
          r_busy  <= 1'b0;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  assign sel_ready_o = r_ready;
  assign en_o        = r_en;
  assign busy_o      = r_busy;
  assign done_o      = r_done;

endmodule

// File: tb/tb_select_decoder_seq.sv
// Scoreboard bench: drivers queue expected enable windows, a monitor checks them.
module tb_select_decoder_seq;

  typedef struct {
    logic [3:0] en;
    int         len;   // expected window length; 0 = truncated, not checked
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] sel_i;
  logic       sel_valid_i;
  logic       sel_ready_o;
  logic       flush_i;
  logic [3:0] en_o;
  logic       busy_o;
  logic       done_o;

  logic [1:0] b_sel;
  logic       b_valid;
  logic       b_ready;
  logic       b_flush;
  logic [3:0] b_en;
  logic       b_busy;
  logic       b_done;

  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  exp_t q[$];

  select_decoder_seq #(
    .SEL_W(2), .HOLD_CYCLES(4), .GUARD_CYCLES(2), .CNT_W(4)
  ) dut (
    .clk(clk), .rst(rst), .sel_i(sel_i), .sel_valid_i(sel_valid_i),
    .sel_ready_o(sel_ready_o), .flush_i(flush_i), .en_o(en_o),
    .busy_o(busy_o), .done_o(done_o)
  );

  select_decoder_seq #(
    .SEL_W(2), .HOLD_CYCLES(1), .GUARD_CYCLES(0), .CNT_W(4)
  ) dut_b (
    .clk(clk), .rst(rst), .sel_i(b_sel), .sel_valid_i(b_valid),
    .sel_ready_o(b_ready), .flush_i(b_flush), .en_o(b_en),
    .busy_o(b_busy), .done_o(b_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Offer a code (negedge-aligned), queue its expected window, optionally flush.
  task automatic send(input logic [1:0] code, input logic [3:0] exp_en,
                      input int exp_len, input int flush_at,
                      input bit keep_valid, output int acc);
    int   n;
    exp_t e;
    sel_i       = code;
    sel_valid_i = 1'b1;
    n = 0;
    while (!sel_ready_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("accept_ready", 32'(sel_ready_o), 32'd1);
    acc   = cyc;
    e.en  = exp_en;
    e.len = exp_len;
    q.push_back(e);
    @(negedge clk);
    if (!keep_valid) sel_valid_i = 1'b0;
    if (flush_at >= 1) begin
      for (int k = 1; k < flush_at; k++) @(negedge clk);
      flush_i = 1'b1;
      @(negedge clk);
      flush_i = 1'b0;
    end
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!sel_ready_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("wait_ready", 32'(sel_ready_o), 32'd1);
  endtask

  // Monitor: pops an expectation at each window start, checks shape and done.
  logic [3:0] m_cur;
  int         m_len;
  int         m_run;
  bit         m_in = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      m_in  = 1'b0;
      m_run = 0;
    end else begin
      chk("onehot", 32'($countones(en_o) <= 1), 32'd1);
      if (en_o != 4'd0 && !m_in) begin
        if (q.size() == 0) begin
          chk("unexpected_window", 32'(en_o), 32'd0);
          m_cur = en_o;
          m_len = 0;
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("window_code", 32'(en_o), 32'(e.en));
          m_cur = e.en;
          m_len = e.len;
        end
        chk("busy_active", 32'(busy_o), 32'd1);
        m_in  = 1'b1;
        m_run = 1;
      end else if (en_o != 4'd0) begin
        chk("en_steady", 32'(en_o), 32'(m_cur));
        m_run++;
      end else if (m_in) begin
        chk("done_pulse", 32'(done_o), 32'd1);
        if (m_len > 0) chk("hold_len", 32'(m_run), 32'(m_len));
        m_in = 1'b0;
      end else begin
        chk("done_idle", 32'(done_o), 32'd0);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, a1;
    exp_t e;
    rst = 1'b1; sel_i = 2'd0; sel_valid_i = 1'b0; flush_i = 1'b0;
    b_sel = 2'd0; b_valid = 1'b0; b_flush = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_en", 32'(en_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", 32'(sel_ready_o), 32'd1);
    chk("post_rst_busy", 32'(busy_o), 32'd0);
    chk("post_rst_done", 32'(done_o), 32'd0);

    // Single accept of code 2; a flush during guard must not shorten the gap.
    send(2'd2, 4'b0100, 4, 5, 1'b0, a0);
    send(2'd0, 4'b0001, 4, -1, 1'b0, a1);
    chk("single_spacing", 32'(a1 - a0), 32'd7);

    // All codes back-to-back with valid held and sel_i changing mid-window.
    wait_ready();
    for (int c = 0; c < 4; c++) begin
      logic [3:0] oh [4];
      oh[0] = 4'b0001; oh[1] = 4'b0010; oh[2] = 4'b0100; oh[3] = 4'b1000;
      a0 = a1;
      send(2'(c), oh[c], 4, -1, 1'b1, a1);
      if (c > 0) chk("b2b_spacing", 32'(a1 - a0), 32'd7);
    end
    sel_valid_i = 1'b0;

    // Flush on the second active cycle of code 3.
    send(2'd3, 4'b1000, 2, 2, 1'b1, a0);
    send(2'd1, 4'b0010, 4, -1, 1'b0, a1);
    chk("flush_spacing", 32'(a1 - a0), 32'd5);

    // Flush with valid in IDLE: nothing accepted.
    wait_ready();
    sel_i = 2'd2; sel_valid_i = 1'b1; flush_i = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("flush_idle_busy", 32'(busy_o), 32'd0);
      chk("flush_idle_en", 32'(en_o), 32'd0);
    end
    flush_i = 1'b0;
    send(2'd2, 4'b0100, 4, -1, 1'b0, a0);

    // Async reset in the middle of an active window.
    wait_ready();
    e.en = 4'b0100; e.len = 0; q.push_back(e);
    sel_i = 2'd2; sel_valid_i = 1'b1;
    @(negedge clk);
    sel_valid_i = 1'b0;
    @(negedge clk);
    chk("pre_rst_en", 32'(en_o), 32'h4);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_en", 32'(en_o), 32'd0);
    chk("async_rst_busy", 32'(busy_o), 32'd0);
    chk("async_rst_done", 32'(done_o), 32'd0);
    @(negedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rel_ready", 32'(sel_ready_o), 32'd1);
    chk("rel_busy", 32'(busy_o), 32'd0);

    // HOLD=1, GUARD=0 instance: code 1 held valid alternates enable and done.
    b_sel = 2'd1; b_valid = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      chk("b_en", 32'(b_en), (i % 2 == 1) ? 32'h2 : 32'h0);
      chk("b_done", 32'(b_done), (i % 2 == 0) ? 32'd1 : 32'd0);
    end
    b_valid = 1'b0;

    repeat (10) @(negedge clk);
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
